// File: rtl/qam16_upconverter.sv
// qam16_upconverter: buffers 16-QAM symbols in a small FIFO, holds each one for SPS
// carrier samples and mixes it as I*cos - Q*sin (rounded, saturated) for the DAC path.
module qam16_upconverter #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int SPS        = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [3:0]                   SYM_IN,
  input  logic                         SYM_VALID,
  output logic                         SYM_READY,
  input  logic signed [DATA_WIDTH-1:0] COS_IN,
  input  logic signed [DATA_WIDTH-1:0] SIN_IN,
  input  logic                         CARRIER_VALID,
  output logic signed [OUT_WIDTH-1:0]  DOUT,
  output logic                         DOUT_VALID,
  output logic                         SYM_STROBE,
  output logic                         UNDERRUN
);
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int PW   = DATA_WIDTH + 3;
  localparam int SUMW = DATA_WIDTH + 4;
  localparam int SW   = DATA_WIDTH + 2;

  localparam logic [AW:0]            FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]            CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]          PTR_ONE  = AW'(1);
  localparam logic [CW-1:0]          CNTR_ONE = CW'(1);
  localparam logic [CW-1:0]          CNT_LAST = CW'(SPS - 1);
  localparam logic signed [SUMW-1:0] RND_BIAS = SUMW'(2);
  localparam logic signed [SW-1:0]   SAT_MAX  = {{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0]   SAT_MIN  = {{(SW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  function automatic logic signed [2:0] gray_level(input logic [1:0] g);
    case (g)
      2'b00:   gray_level = 3'sb101;
      2'b01:   gray_level = 3'sb111;
      2'b11:   gray_level = 3'sb001;
      2'b10:   gray_level = 3'sb011;
      default: gray_level = 3'sb000;
    endcase
  endfunction

  logic [3:0]               fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]              count_q, count_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic signed [2:0]        i_lvl_q, i_lvl_d, q_lvl_q, q_lvl_d;
  logic signed [2:0]        i_cur, q_cur;
  logic                     underrun_q, underrun_d;
  logic                     push, pop, boundary, fifo_empty;
  logic [3:0]               head;
  logic signed [PW-1:0]     i_ext, q_ext, cos_ext, sin_ext;
  logic signed [PW-1:0]     prod_i_q, prod_i_d, prod_q_q, prod_q_d;
  logic                     v1_q, v1_d, st1_q, st1_d;
  logic signed [SUMW-1:0]   diff;
  logic signed [SW-1:0]     rnd_q, rnd_d;
  logic                     v2_q, v2_d, st2_q, st2_d;
  logic signed [OUT_WIDTH-1:0] dout_q, dout_d;
  logic                     dout_valid_q, dout_valid_d, sym_strobe_q, sym_strobe_d;

  assign SYM_READY  = (count_q != FULL_CNT) && !RST;
  assign DOUT       = dout_q;
  assign DOUT_VALID = dout_valid_q;
  assign SYM_STROBE = sym_strobe_q;
  assign UNDERRUN   = underrun_q;

  always_comb begin
    fifo_empty = (count_q == '0);
    head       = fifo_mem_q[rd_ptr_q];
    push       = SYM_VALID && SYM_READY;
    boundary   = CARRIER_VALID && (cnt_q == '0);
    pop        = boundary && !fifo_empty;

    wr_ptr_d   = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d   = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // The symbol taking effect at a boundary drives this very sample, not the next.
    i_cur      = i_lvl_q;
    q_cur      = q_lvl_q;
    underrun_d = underrun_q;
    if (boundary) begin
      if (!fifo_empty) begin
        i_cur = gray_level(head[3:2]);
        q_cur = gray_level(head[1:0]);
      end else begin
        i_cur      = 3'sb000;
        q_cur      = 3'sb000;
        underrun_d = 1'b1;
      end
    end

    cnt_d   = cnt_q;
    i_lvl_d = i_lvl_q;
    q_lvl_d = q_lvl_q;
    if (CARRIER_VALID) begin
      cnt_d   = (cnt_q == CNT_LAST) ? '0 : (cnt_q + CNTR_ONE);
      i_lvl_d = i_cur;
      q_lvl_d = q_cur;
    end

    i_ext    = {{DATA_WIDTH{i_cur[2]}}, i_cur};
    q_ext    = {{DATA_WIDTH{q_cur[2]}}, q_cur};
    cos_ext  = {{3{COS_IN[DATA_WIDTH-1]}}, COS_IN};
    sin_ext  = {{3{SIN_IN[DATA_WIDTH-1]}}, SIN_IN};
    v1_d     = CARRIER_VALID;
    st1_d    = boundary;
    prod_i_d = prod_i_q;
    prod_q_d = prod_q_q;
    if (CARRIER_VALID) begin
      prod_i_d = i_ext * cos_ext;
      prod_q_d = q_ext * sin_ext;
    end

    // Bias and drop the two fraction bits together so only the kept bits are registered.
    diff  = {prod_i_q[PW-1], prod_i_q} - {prod_q_q[PW-1], prod_q_q};
    v2_d  = v1_q;
    st2_d = st1_q;
    rnd_d = rnd_q;
    if (v1_q) begin
      rnd_d = SW'((diff + RND_BIAS) >>> 2);
    end

    dout_valid_d = v2_q;
    sym_strobe_d = st2_q;
    dout_d       = dout_q;
    if (v2_q) begin
      if (rnd_q > SAT_MAX) begin
        dout_d = SAT_MAX[OUT_WIDTH-1:0];
      end else if (rnd_q < SAT_MIN) begin
        dout_d = SAT_MIN[OUT_WIDTH-1:0];
      end else begin
        dout_d = rnd_q[OUT_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= SYM_IN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cnt_q        <= '0;
      i_lvl_q      <= 3'sb000;
      q_lvl_q      <= 3'sb000;
      underrun_q   <= 1'b0;
      prod_i_q     <= '0;
      prod_q_q     <= '0;
      v1_q         <= 1'b0;
      st1_q        <= 1'b0;
      rnd_q        <= '0;
      v2_q         <= 1'b0;
      st2_q        <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sym_strobe_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      cnt_q        <= cnt_d;
      i_lvl_q      <= i_lvl_d;
      q_lvl_q      <= q_lvl_d;
      underrun_q   <= underrun_d;
      prod_i_q     <= prod_i_d;
      prod_q_q     <= prod_q_d;
      v1_q         <= v1_d;
      st1_q        <= st1_d;
      rnd_q        <= rnd_d;
      v2_q         <= v2_d;
      st2_q        <= st2_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sym_strobe_q <= sym_strobe_d;
    end
  end
endmodule

// File: tb/tb_qam16_upconverter.sv
// Scoreboard bench for qam16_upconverter: an integer reference model predicts every
// passband sample; a negedge monitor pops and compares whatever the DUT emits.
module tb_qam16_upconverter;
  localparam int DW = 16, OW = 16, SPS = 8, DEPTH = 4;

  logic clk = 1'b0;
  logic rst, sym_valid, car_valid;
  logic [3:0] sym_in;
  logic signed [DW-1:0] cos_in, sin_in;
  logic sym_ready, dout_valid, sym_strobe, underrun;
  logic signed [OW-1:0] dout;

  always #5 clk = ~clk;

  qam16_upconverter #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .SPS(SPS), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(clk), .RST(rst), .SYM_IN(sym_in), .SYM_VALID(sym_valid), .SYM_READY(sym_ready),
    .COS_IN(cos_in), .SIN_IN(sin_in), .CARRIER_VALID(car_valid),
    .DOUT(dout), .DOUT_VALID(dout_valid), .SYM_STROBE(sym_strobe), .UNDERRUN(underrun)
  );

  typedef struct { int val; bit stb; int due; } exp_t;
  typedef struct { int val; bit stb; } obs_t;

  int n_checks = 0, n_fail = 0, cyc = 0;
  bit started = 1'b0;
  exp_t sb[$];
  obs_t log_q[$];
  logic [3:0] m_fifo[$];
  int m_cnt = 0, m_i = 0, m_q = 0;
  bit m_und = 1'b0, m_push, m_stb;
  logic [3:0] m_s;
  exp_t e_new;
  bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [3:0] syms [6] = '{4'h1, 4'h6, 4'hB, 4'hC, 4'h4, 4'h9};

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int level(input logic [1:0] g);
    int idx;
    idx = {g[1], g[1] ^ g[0]};
    return 2 * idx - 3;
  endfunction

  function automatic int expect_sample(input int i, input int q, input int c, input int s);
    int v, lim;
    v   = (i * c - q * s + 2) >>> 2;
    lim = (1 << (OW - 1));
    if (v > lim - 1) v = lim - 1;
    if (v < -lim) v = -lim;
    return v;
  endfunction

  // Reference model: symbol queue, sample counter and sticky underrun at each edge.
  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      m_fifo.delete();
      sb.delete();
      m_cnt = 0;
      m_und = 1'b0;
      m_i = 0;
      m_q = 0;
    end else begin
      m_push = sym_valid && (m_fifo.size() < DEPTH);
      if (car_valid) begin
        m_stb = (m_cnt == 0);
        if (m_stb) begin
          if (m_fifo.size() > 0) begin
            m_s = m_fifo.pop_front();
            m_i = level(m_s[3:2]);
            m_q = level(m_s[1:0]);
          end else begin
            m_i = 0;
            m_q = 0;
            m_und = 1'b1;
          end
        end
        e_new.val = expect_sample(m_i, m_q, cos_in, sin_in);
        e_new.stb = m_stb;
        e_new.due = cyc + 3;
        sb.push_back(e_new);
        m_cnt = (m_cnt + 1) % SPS;
      end
      if (m_push) m_fifo.push_back(sym_in);
    end
    cyc++;
  end

  // Monitor: compares handshake/sticky flags every cycle and pops one expectation per valid output.
  always begin
    exp_t e;
    obs_t o;
    @(negedge clk);
    #3;
    if (started) begin
      chk("sym_ready", sym_ready, (!rst && m_fifo.size() < DEPTH));
      chk("underrun", underrun, m_und);
      if (dout_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("dout_valid_unexpected", dout_valid, 0);
        end else begin
          e = sb.pop_front();
          chk("dout", dout, e.val);
          chk("sym_strobe", sym_strobe, e.stb);
          chk("latency", cyc, e.due);
          o.val = dout;
          o.stb = sym_strobe;
          log_q.push_back(o);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        chk("dout_valid_missing", dout_valid, 1);
        void'(sb.pop_front());
      end
    end
  end

  task automatic push_sym(input logic [3:0] s);
    sym_in = s;
    sym_valid = 1'b1;
    car_valid = 1'b0;
    @(negedge clk);
    sym_valid = 1'b0;
  endtask

  task automatic run(input int n, input bit rnd);
    car_valid = 1'b1;
    repeat (n) begin
      if (rnd) begin
        cos_in = DW'($urandom);
        sin_in = DW'($urandom);
      end
      @(negedge clk);
    end
    car_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    car_valid = 1'b0;
    sym_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int idx;
    bit r;
    logic obs [10];
    rst = 1'b1; sym_valid = 1'b0; sym_in = 4'h0; car_valid = 1'b0;
    cos_in = 16'sd0; sin_in = 16'sd32767;

    // Reset with random inputs.
    for (int k = 0; k < 3; k++) begin
      sym_valid = 1'($urandom); sym_in = 4'($urandom); car_valid = 1'($urandom);
      cos_in = DW'($urandom); sin_in = DW'($urandom);
      @(negedge clk);
      #1;
      chk("rst_dout", dout, 0);
      chk("rst_dout_valid", dout_valid, 0);
      chk("rst_sym_strobe", sym_strobe, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_sym_ready", sym_ready, 0);
    end
    rst = 1'b0; sym_valid = 1'b0; car_valid = 1'b0; cos_in = 16'sd0; sin_in = 16'sd32767;
    #1;
    chk("ready_after_rst", sym_ready, 1);
    chk("dout_after_rst", dout, 0);
    @(negedge clk);

    // Single symbol then underrun.
    push_sym(4'b1010);
    log_q.delete();
    run(16, 1'b0);
    idle(4);
    chk("single_count", log_q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      chk("single_val", log_q[i].val, (i < 8) ? -24575 : 0);
      chk("single_stb", log_q[i].stb, (i == 0 || i == 8) ? 1 : 0);
    end
    chk("single_underrun", underrun, 1);

    // Carrier gaps: DOUT_VALID follows CARRIER_VALID three cycles later.
    push_sym(4'b0111);
    push_sym(4'b1100);
    log_q.delete();
    for (int k = 0; k < 10; k++) begin
      car_valid = (k < 7) ? pat[k] : 1'b0;
      cos_in = DW'($urandom); sin_in = DW'($urandom);
      @(negedge clk);
      #1;
      obs[k] = dout_valid;
    end
    for (int k = 0; k < 10; k++) begin
      chk("gap_valid", obs[k], (k >= 2 && k < 9) ? pat[k-2] : 1'b0);
    end
    run(12, 1'b1);
    idle(4);
    chk("gap_count", log_q.size(), 16);

    // Backpressure with no carrier.
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idx = 0;
    repeat (6) begin
      sym_in = syms[idx]; sym_valid = 1'b1; car_valid = 1'b0;
      #1;
      r = sym_ready;
      @(negedge clk);
      if (r) idx++;
    end
    chk("bp_accepted", idx, 4);
    chk("bp_ready_full", sym_ready, 0);
    sym_in = syms[4]; sym_valid = 1'b1; car_valid = 1'b1;
    cos_in = DW'($urandom); sin_in = DW'($urandom);
    #1;
    chk("bp_ready_before_pop", sym_ready, 0);
    @(negedge clk);
    car_valid = 1'b0;
    #1;
    chk("bp_ready_after_pop", sym_ready, 1);
    @(negedge clk);
    #1;
    chk("bp_ready_refull", sym_ready, 0);
    sym_valid = 1'b0;
    run(39, 1'b1);
    idle(4);

    // Saturation clamps.
    push_sym(4'b1000);
    push_sym(4'b1000);
    log_q.delete();
    cos_in = 16'sd32767; sin_in = 16'sd32767;
    run(8, 1'b0);
    cos_in = -16'sd32768; sin_in = -16'sd32768;
    run(8, 1'b0);
    idle(4);
    chk("sat_count", log_q.size(), 16);
    chk("sat_pos", log_q[0].val, 32767);
    chk("sat_neg", log_q[8].val, -32768);

    // Reset mid-symbol with two symbols queued.
    run(8, 1'b1);
    idle(1);
    chk("pre_rst_underrun", underrun, 1);
    push_sym(4'h3);
    push_sym(4'hA);
    push_sym(4'h5);
    run(4, 1'b1);
    rst = 1'b1; car_valid = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_dout_valid", dout_valid, 0);
    chk("midrst_underrun", underrun, 0);
    rst = 1'b0; car_valid = 1'b0;
    log_q.delete();
    @(negedge clk);
    #1;
    chk("midrst_no_stale", dout_valid, 0);
    run(1, 1'b1);
    idle(4);
    chk("midrst_count", log_q.size(), 1);
    chk("midrst_val", log_q[0].val, 0);
    chk("midrst_stb", log_q[0].stb, 1);
    chk("midrst_underrun_set", underrun, 1);

    // Randomised traffic with occasional resets.
    for (int k = 0; k < 800; k++) begin
      rst = ($urandom_range(0, 149) == 0);
      car_valid = ($urandom_range(0, 9) < 7);
      sym_valid = 1'($urandom);
      sym_in = 4'($urandom);
      cos_in = ($urandom_range(0, 7) == 0) ? -16'sd32768 : DW'($urandom);
      sin_in = ($urandom_range(0, 7) == 0) ? 16'sd32767 : DW'($urandom);
      @(negedge clk);
    end
    rst = 1'b0;
    idle(6);
    chk("scoreboard_drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
